// File: rtl/e_mdu_param_pkg.sv
// e_mdu_param_pkg: shared constants for the parametrised E-stage multiply/divide unit.
//   - MDUOp operation codes (4 bits)
//   - counter width for the busy-cycle counter
//   - helpers that classify an opcode into the multiply or divide latency class
package e_mdu_param_pkg;

   localparam int MDU_OP_W  = 4;
   localparam int MDU_CTR_W = 6;

   localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'd0;
   localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
   localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
   localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
   localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
   localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd5;
   localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd6;
   localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd7;
   localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd8;
   localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'd9;
   localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'd10;

   // True for every op that uses the multiply latency class.
   function automatic logic is_mult_op(input logic [MDU_OP_W-1:0] op);
      logic r;
      case (op)
         MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // True for every op that uses the divide latency class.
   function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
      logic r;
      case (op)
         MDU_DIV, MDU_DIVU: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/e_mdu_param_arith.sv
// mdu_arith: purely combinational datapath of the MDU.
//   op_i        MDUOp code
//   a_i, b_i    operands (rs, rt)
//   hi_i, lo_i  current HI/LO (accumulator input for MADD*/MSUB*)
//   res_hi_o    next HI value for the op
//   res_lo_o    next LO value for the op
//   div_zero_o  DIV/DIVU with b_i == 0; result then equals the current HI/LO
module mdu_arith
   import e_mdu_param_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [MDU_OP_W-1:0] op_i,
   input  logic [WIDTH-1:0]    a_i,
   input  logic [WIDTH-1:0]    b_i,
   input  logic [WIDTH-1:0]    hi_i,
   input  logic [WIDTH-1:0]    lo_i,
   output logic [WIDTH-1:0]    res_hi_o,
   output logic [WIDTH-1:0]    res_lo_o,
   output logic                div_zero_o
);

   localparam int W2 = 2 * WIDTH;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [W2-1:0]           acc_s;
   logic [W2-1:0]           prod_s_s;
   logic [W2-1:0]           prod_u_s;
   logic [W2-1:0]           res_s;
   logic [WIDTH-1:0]        divisor_s;
   logic signed [WIDTH-1:0] quot_s_s;
   logic signed [WIDTH-1:0] rem_s_s;
   logic [WIDTH-1:0]        quot_u_s;
   logic [WIDTH-1:0]        rem_u_s;
   logic                    b_zero_s;
   logic                    div_ovf_s;

   assign acc_s     = {hi_i, lo_i};
   // Operands sign/zero-extended to 2*WIDTH so the low 2*WIDTH product bits are exact.
   assign prod_s_s  = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
   assign prod_u_s  = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
   assign b_zero_s  = (b_i == {WIDTH{1'b0}});
   // A harmless divisor keeps the dividers well defined when b is zero.
   assign divisor_s = b_zero_s ? ONE : b_i;
   assign div_ovf_s = (a_i == MOST_NEG) && (b_i == ALL_ONES);
   assign quot_s_s  = $signed(a_i) / $signed(divisor_s);
   assign rem_s_s   = $signed(a_i) % $signed(divisor_s);
   assign quot_u_s  = a_i / divisor_s;
   assign rem_u_s   = a_i % divisor_s;

   // Result select per opcode; anything non-arithmetic passes HI/LO through.
   always_comb begin
      res_s      = acc_s;
      div_zero_o = 1'b0;
      case (op_i)
         MDU_MULT:  res_s = prod_s_s;
         MDU_MULTU: res_s = prod_u_s;
         MDU_MADD:  res_s = acc_s + prod_s_s;
         MDU_MADDU: res_s = acc_s + prod_u_s;
         MDU_MSUB:  res_s = acc_s - prod_s_s;
         MDU_MSUBU: res_s = acc_s - prod_u_s;
         MDU_DIV: begin
            if (b_zero_s) begin
               div_zero_o = 1'b1;
            end else if (div_ovf_s) begin
               res_s = {{WIDTH{1'b0}}, MOST_NEG};
            end else begin
               res_s = {rem_s_s, quot_s_s};
            end
         end
         MDU_DIVU: begin
            if (b_zero_s) begin
               div_zero_o = 1'b1;
            end else begin
               res_s = {rem_u_s, quot_u_s};
            end
         end
         default: res_s = acc_s;
      endcase
   end

   assign res_hi_o = res_s[W2-1:WIDTH];
   assign res_lo_o = res_s[WIDTH-1:0];

endmodule

// File: rtl/e_mdu_param.sv
// e_mdu_param: parametrised multi-cycle multiply/divide unit for the E stage.
//   clk, reset  clock and synchronous active-high reset
//   Req         exception/interrupt request; blocks acceptance of a new op
//   Start       E-stage instruction is an MDU op
//   MDUOp       operation code (see e_mdu_param_pkg)
//   A, B        forwarded rs / rt values
//   Busy        multi-cycle op in flight
//   Done        one-cycle pulse when HI/LO first show a multi-cycle result
//   HI, LO      architectural HI / LO registers
module e_mdu_param
   import e_mdu_param_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                Req,
   input  logic                Start,
   input  logic [MDU_OP_W-1:0] MDUOp,
   input  logic [WIDTH-1:0]    A,
   input  logic [WIDTH-1:0]    B,
   output logic                Busy,
   output logic                Done,
   output logic [WIDTH-1:0]    HI,
   output logic [WIDTH-1:0]    LO
);

   localparam logic [MDU_CTR_W-1:0] MULT_N   = MDU_CTR_W'(MULT_CYCLES);
   localparam logic [MDU_CTR_W-1:0] DIV_N    = MDU_CTR_W'(DIV_CYCLES);
   localparam logic [MDU_CTR_W-1:0] CTR_ONE  = 6'd1;
   localparam logic [MDU_CTR_W-1:0] CTR_ZERO = 6'd0;

   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic                 pend_wr_q, pend_wr_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic [MDU_CTR_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]     res_hi_s, res_lo_s;
   logic                 div_zero_s;
   logic                 accept_s;

   mdu_arith #(.WIDTH(WIDTH)) u_arith (
      .op_i       (MDUOp),
      .a_i        (A),
      .b_i        (B),
      .hi_i       (hi_q),
      .lo_i       (lo_q),
      .res_hi_o   (res_hi_s),
      .res_lo_o   (res_lo_s),
      .div_zero_o (div_zero_s)
   );

   assign accept_s = Start && !Req && !busy_q;

   // Next-state: countdown while busy, otherwise accept and dispatch a new op.
   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      if (busy_q) begin
         if (cnt_q == CTR_ONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            cnt_d  = CTR_ZERO;
            // A divide by zero completes without touching HI/LO.
            if (pend_wr_q) begin
               hi_d = pend_hi_q;
               lo_d = pend_lo_q;
            end else begin
               hi_d = hi_q;
            end
         end else begin
            cnt_d = cnt_q - CTR_ONE;
         end
      end else if (accept_s) begin
         if (MDUOp == MDU_MTHI) begin
            hi_d = A;
         end else if (MDUOp == MDU_MTLO) begin
            lo_d = A;
         end else if (is_mult_op(MDUOp) || is_div_op(MDUOp)) begin
            busy_d    = 1'b1;
            cnt_d     = is_div_op(MDUOp) ? DIV_N : MULT_N;
            pend_hi_d = res_hi_s;
            pend_lo_d = res_lo_s;
            pend_wr_d = !div_zero_s;
         end else begin
            busy_d = 1'b0;
         end
      end else begin
         busy_d = busy_q;
      end
   end

   // State registers with synchronous reset; reset aborts any op in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q      <= {WIDTH{1'b0}};
         lo_q      <= {WIDTH{1'b0}};
         pend_hi_q <= {WIDTH{1'b0}};
         pend_lo_q <= {WIDTH{1'b0}};
         pend_wr_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= CTR_ZERO;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cnt_q     <= cnt_d;
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu_param.sv
// tb_e_mdu_param: self-checking bench for e_mdu_param (default latencies) and a
// second instance with single-cycle latencies.
module tb_e_mdu_param;
   import e_mdu_param_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset, Req, Start;
   logic [3:0]  MDUOp;
   logic [31:0] A, B, HI, LO;
   logic        Busy, Done;

   logic        start1;
   logic [3:0]  op1;
   logic [31:0] a1, b1, hi1, lo1;
   logic        busy1, done1;

   int checks = 0;
   int errors = 0;
   logic [63:0] m_acc;   // reference model {HI,LO}

   always #5 clk = ~clk;

   e_mdu_param #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .Req(Req), .Start(Start), .MDUOp(MDUOp),
      .A(A), .B(B), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
   );

   e_mdu_param #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .Req(1'b0), .Start(start1), .MDUOp(op1),
      .A(a1), .B(b1), .Busy(busy1), .Done(done1), .HI(hi1), .LO(lo1)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        req;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t tab[$];

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got busy/done/hi/lo=%h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of an op from its definition (magnitude-based division).
   function automatic logic [63:0] ref_next(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
      longint sa, sb, ma, mb, q, r;
      logic [63:0] ps, pu, res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ps = sa * sb;
      pu = {32'd0, a} * {32'd0, b};
      res = acc;
      case (op)
         4'd1:  res = ps;
         4'd2:  res = pu;
         4'd7:  res = acc + ps;
         4'd8:  res = acc + pu;
         4'd9:  res = acc - ps;
         4'd10: res = acc - pu;
         4'd3: if (b != 32'd0) begin
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            q  = ma / mb;
            r  = ma % mb;
            if ((sa < 0) != (sb < 0)) q = -q;
            if (sa < 0) r = -r;
            res = {r[31:0], q[31:0]};
         end
         4'd4: if (b != 32'd0) res = {a % b, a / b};
         4'd5:  res = {a, acc[31:0]};
         4'd6:  res = {acc[63:32], a};
         default: res = acc;
      endcase
      return res;
   endfunction

   function automatic int latency(input logic [3:0] op);
      if (op == 4'd1 || op == 4'd2 || (op >= 4'd7 && op <= 4'd10)) return MC;
      if (op == 4'd3 || op == 4'd4) return DC;
      return 0;
   endfunction

   // Issue one op (called at a negedge); checks every busy cycle and completion.
   // req_at >= 0 raises Req in that busy cycle index.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic req, input int req_at, input logic use_tab,
                        input logic [31:0] t_hi, input logic [31:0] t_lo);
      logic [63:0] old, exp;
      int lat;
      old = m_acc;
      exp = req ? old : ref_next(op, a, b, old);
      lat = req ? 0 : latency(op);
      Start = 1'b1; MDUOp = op; A = a; B = b; Req = req;
      @(posedge clk);
      @(negedge clk);
      Start = 1'b0; Req = 1'b0;
      A = $urandom; B = $urandom;
      if (lat > 0) begin
         for (int i = 0; i < lat; i++) begin
            chk("busy_cycle", {Busy, Done, HI, LO}, {1'b1, 1'b0, old});
            if (i == req_at) Req = 1'b1;
            @(negedge clk);
         end
         Req = 1'b0;
         chk("complete", {Busy, Done, HI, LO}, {1'b0, 1'b1, exp});
      end else begin
         chk("no_busy", {Busy, Done, HI, LO}, {1'b0, 1'b0, exp});
      end
      if (use_tab) chk("table_value", {2'b00, HI, LO}, {2'b00, t_hi, t_lo});
      m_acc = exp;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; Req = 1'b0; Start = 1'b0; MDUOp = 4'd0; A = 32'd0; B = 32'd0;
      start1 = 1'b0; op1 = 4'd0; a1 = 32'd0; b1 = 32'd0;
      m_acc = 64'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {Busy, Done, HI, LO}, 66'd0);
      chk("reset_state1", {busy1, done1, hi1, lo1}, 66'd0);
      reset = 1'b0;

      tab.push_back('{MDU_MULT,  32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB});
      tab.push_back('{MDU_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
      tab.push_back('{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000});
      tab.push_back('{MDU_MTHI,  32'd5,        32'd0,        1'b0, 32'h00000005, 32'h80000000});
      tab.push_back('{MDU_MTLO,  32'hFFFFFFFF, 32'd0,        1'b0, 32'h00000005, 32'hFFFFFFFF});
      tab.push_back('{MDU_MADDU, 32'd1,        32'd1,        1'b0, 32'h00000006, 32'h00000000});
      tab.push_back('{MDU_MTHI,  32'h11,       32'd0,        1'b0, 32'h00000011, 32'h00000000});
      tab.push_back('{MDU_MTLO,  32'h22,       32'd0,        1'b0, 32'h00000011, 32'h00000022});
      tab.push_back('{MDU_DIVU,  32'h1234,     32'd0,        1'b0, 32'h00000011, 32'h00000022});
      tab.push_back('{MDU_MULT,  32'd2,        32'd3,        1'b1, 32'h00000011, 32'h00000022});
      tab.push_back('{MDU_NONE,  32'd9,        32'd9,        1'b0, 32'h00000011, 32'h00000022});
      tab.push_back('{4'd13,     32'd9,        32'd9,        1'b0, 32'h00000011, 32'h00000022});
      tab.push_back('{MDU_MSUB,  32'd2,        32'hFFFFFFFF, 1'b0, 32'h00000011, 32'h00000024});
      tab.push_back('{MDU_MULT,  32'd2,        32'd3,        1'b0, 32'h00000000, 32'h00000006});
      for (int i = 0; i < tab.size(); i++)
         do_op(tab[i].op, tab[i].a, tab[i].b, tab[i].req, -1, 1'b1, tab[i].hi, tab[i].lo);

      // Req raised in busy cycle 2 of a MULT must not disturb it.
      do_op(MDU_MULT, 32'd2, 32'd3, 1'b0, 1, 1'b1, 32'd0, 32'd6);

      // Randomised ops against the reference model.
      for (int n = 0; n < 60; n++) begin
         logic [3:0]  rop;
         logic [31:0] ra, rb;
         rop = 4'($urandom_range(0, 15));
         ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         rb  = ($urandom_range(0, 5) == 0) ? 32'd0 :
               ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
         do_op(rop, ra, rb, ($urandom_range(0, 7) == 0), $urandom_range(0, 12), 1'b0,
               32'd0, 32'd0);
      end

      // Reset in busy cycle 3 of a DIV aborts it.
      do_op(MDU_MTHI, 32'hABCD, 32'd0, 1'b0, -1, 1'b0, 32'd0, 32'd0);
      Start = 1'b1; MDUOp = MDU_DIV; A = 32'd100; B = 32'd7;
      @(posedge clk);
      @(negedge clk);
      Start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("busy_before_reset", {Busy, Done, HI, LO}, {1'b1, 1'b0, m_acc});
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("reset_mid_op", {Busy, Done, HI, LO}, 66'd0);
      reset = 1'b0;
      m_acc = 64'd0;
      repeat (DC) begin
         @(negedge clk);
         chk("after_reset_idle", {Busy, Done, HI, LO}, 66'd0);
      end

      // Single-cycle latency instance.
      start1 = 1'b1; op1 = MDU_MULT; a1 = 32'd2; b1 = 32'd3;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      chk("lat1_mult_busy", {busy1, done1, hi1, lo1}, {1'b1, 1'b0, 64'd0});
      @(negedge clk);
      chk("lat1_mult_done", {busy1, done1, hi1, lo1}, {1'b0, 1'b1, 32'd0, 32'd6});
      start1 = 1'b1; op1 = MDU_DIV; a1 = 32'd7; b1 = 32'd2;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      chk("lat1_div_busy", {busy1, done1, hi1, lo1}, {1'b1, 1'b0, 32'd0, 32'd6});
      @(negedge clk);
      chk("lat1_div_done", {busy1, done1, hi1, lo1}, {1'b0, 1'b1, 32'd1, 32'd3});
      @(negedge clk);
      chk("lat1_idle", {busy1, done1, hi1, lo1}, {1'b0, 1'b0, 32'd1, 32'd3});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
